bram_loader: RTL and testbench

BRAM_LOADER -- requirements
Module: bram_loader

---
 rtl/bram_loader_if.sv | 23 ++
 rtl/bram_loader.sv | 143 ++++++++++++++
 tb/tb_bram_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_loader_if.sv
// Upstream word stream plus BRAM write port of the frame loader.
// The loader uses the slave modport; the data source and BRAM side use master.
interface bram_loader_if #(
   parameter int ADDR_W = 9
) ();
   logic [31:0]       s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_din;
   logic [3:0]        bram_we;
   logic              bram_en;

   modport slave (
      input  s_data, s_valid,
      output s_ready, bram_addr, bram_din, bram_we, bram_en
   );

   modport master (
      output s_data, s_valid,
      input  s_ready, bram_addr, bram_din, bram_we, bram_en
   );
endinterface

// File: rtl/bram_loader.sv
// Loads one frame of stream words into a BRAM and then releases the user application for frame_len+RUN_SLACK cycles.
// Optional running checksum of accepted words is enabled by defining BRAM_LOADER_CHKSUM_EN.
module bram_loader #(
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 512,
   parameter int RUN_SLACK = 2
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         start,
   input  logic [9:0]   frame_len,
   bram_loader_if.slave bif,
   output logic         wr_wren,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [9:0]   word_count,
   output logic [31:0]  checksum
);

   localparam int          CNT_W   = $clog2(DEPTH + RUN_SLACK + 1);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [9:0]        len_q, len_d;
   logic [9:0]        word_count_q, word_count_d;
   logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic              en_q, en_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic len_legal, start_ok, start_bad, xfer, last_xfer, rel_last;

   assign len_legal = (frame_len != 10'd0) && ({22'd0, frame_len} <= DEPTH_U);
   assign start_ok  = (state_q == IDLE) && start && len_legal;
   assign start_bad = (state_q == IDLE) && start && !len_legal;
   assign xfer      = (state_q == LOAD) && bif.s_valid;
   assign last_xfer = xfer && (word_count_q == (len_q - 10'd1));
   assign rel_last  = (state_q == RELEASE) && (rel_cnt_q == CNT_W'(1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         len_q        <= '0;
         word_count_q <= '0;
         rel_cnt_q    <= '0;
         addr_q       <= '0;
         din_q        <= '0;
         en_q         <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_count_q <= word_count_d;
         rel_cnt_q    <= rel_cnt_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         en_q         <= en_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok)  state_d = LOAD;
         LOAD:    if (last_xfer) state_d = RELEASE;
         RELEASE: if (rel_last)  state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Write port is registered: a word accepted on this edge is written on the next cycle.
   always_comb begin
      len_d        = len_q;
      word_count_d = word_count_q;
      rel_cnt_d    = rel_cnt_q;
      addr_d       = addr_q;
      din_d        = din_q;
      en_d         = 1'b0;
      done_d       = 1'b0;
      err_d        = start_bad;
      if (start_ok) begin
         len_d        = frame_len;
         word_count_d = '0;
      end
      if (xfer) begin
         addr_d       = ADDR_W'(word_count_q);
         din_d        = bif.s_data;
         en_d         = 1'b1;
         word_count_d = word_count_q + 10'd1;
      end
      // Counter is loaded so RELEASE lasts exactly frame_len+RUN_SLACK cycles.
      if (last_xfer) begin
         rel_cnt_d = CNT_W'(len_q) + CNT_W'(RUN_SLACK);
      end else if (state_q == RELEASE) begin
         rel_cnt_d = rel_cnt_q - CNT_W'(1);
      end
      if (rel_last) done_d = 1'b1;
   end

   always_comb begin
      bif.s_ready   = (state_q == LOAD);
      busy          = (state_q != IDLE);
      wr_wren       = (state_q != RELEASE);
      bif.bram_addr = addr_q;
      bif.bram_din  = din_q;
      bif.bram_en   = en_q;
      bif.bram_we   = {4{en_q}};
      done          = done_q;
      err           = err_q;
      word_count    = word_count_q;
   end

`ifdef BRAM_LOADER_CHKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (start_ok) begin
         checksum_d = '0;
      end else if (xfer) begin
         checksum_d = checksum_q + bif.s_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) checksum_q <= '0;
      else         checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: frame loads, gaps, illegal lengths, full depth, mid-frame reset, ignored starts.
module tb_bram_loader;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [9:0] frame_len;
   logic       wr_wren, busy, done, err;
   logic [9:0] word_count;
   logic [31:0] checksum;

   bram_loader_if #(.ADDR_W(9)) bif ();

   bram_loader #(.ADDR_W(9), .DEPTH(512), .RUN_SLACK(2)) dut (
      .clock(clock), .resetn(resetn), .start(start), .frame_len(frame_len),
      .bif(bif), .wr_wren(wr_wren), .busy(busy), .done(done), .err(err),
      .word_count(word_count), .checksum(checksum)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor: sampled on the falling edge, counters only ever increment.
   int wr_cnt = 0, done_cnt = 0, err_cnt = 0, low_cnt = 0, a0_cnt = 0, we_bad = 0;
   logic [8:0]  wr_addr [0:2047];
   logic [31:0] wr_data [0:2047];

   always @(negedge clock) begin
      if (bif.bram_en) begin
         if (wr_cnt < 2048) begin
            wr_addr[wr_cnt] = bif.bram_addr;
            wr_data[wr_cnt] = bif.bram_din;
         end
         wr_cnt++;
         if (bif.bram_we != 4'hF) we_bad++;
         if (bif.bram_addr == 9'd0) a0_cnt++;
      end else if (bif.bram_we != 4'h0) begin
         we_bad++;
      end
      if (done)     done_cnt++;
      if (err)      err_cnt++;
      if (!wr_wren) low_cnt++;
   end

   int b_wr, b_done, b_err, b_low, b_a0, b_we;

   task automatic snap();
      b_wr = wr_cnt; b_done = done_cnt; b_err = err_cnt;
      b_low = low_cnt; b_a0 = a0_cnt; b_we = we_bad;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      n = 0;
      while ((done_cnt == b_done) && (n < limit)) begin
         step();
         n++;
      end
      chk(tag, (done_cnt != b_done) ? 32'd1 : 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] exp_cs(input logic [31:0] v);
`ifdef BRAM_LOADER_CHKSUM_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_s_ready"}, 32'(bif.s_ready), 32'd0);
      chk({tag, "_en"},      32'(bif.bram_en), 32'd0);
      chk({tag, "_we"},      32'(bif.bram_we), 32'd0);
      chk({tag, "_addr"},    32'(bif.bram_addr), 32'd0);
      chk({tag, "_din"},     bif.bram_din, 32'd0);
      chk({tag, "_wr_wren"}, 32'(wr_wren), 32'd1);
      chk({tag, "_busy"},    32'(busy), 32'd0);
      chk({tag, "_done"},    32'(done), 32'd0);
      chk({tag, "_err"},     32'(err), 32'd0);
      chk({tag, "_wcount"},  32'(word_count), 32'd0);
      chk({tag, "_cs"},      checksum, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; start = 1'b0; frame_len = '0;
      bif.s_valid = 1'b0; bif.s_data = '0;

      // Reset values, before and after clock edges with reset held
      #3;
      chk_idle_reset("rst0");
      step(); step();
      chk_idle_reset("rst1");

      // Frame of 4 back-to-back; start on the first edge after reset release
      resetn = 1'b1;
      snap();
      start = 1'b1; frame_len = 10'd4;
      step();
      start = 1'b0;
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready", 32'(bif.s_ready), 32'd1);
      chk("t1_wc0", 32'(word_count), 32'd0);
      bif.s_valid = 1'b1;
      bif.s_data = 32'h11; step();
      bif.s_data = 32'h22; step();
      bif.s_data = 32'h33; step();
      bif.s_data = 32'h44; step();
      bif.s_valid = 1'b0;
      chk("t1_ready_drop", 32'(bif.s_ready), 32'd0);
      chk("t1_final_en", 32'(bif.bram_en), 32'd1);
      chk("t1_final_addr", 32'(bif.bram_addr), 32'd3);
      wait_done("t1_done_seen", 30);
      step(); step();
      chk("t1_writes", 32'(wr_cnt - b_wr), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("t1_addr", 32'(wr_addr[b_wr + k]), 32'(k));
         chk("t1_data", wr_data[b_wr + k], 32'h11 * 32'(k + 1));
      end
      chk("t1_we_bad", 32'(we_bad - b_we), 32'd0);
      chk("t1_wren_low", 32'(low_cnt - b_low), 32'd6);
      chk("t1_done_cnt", 32'(done_cnt - b_done), 32'd1);
      chk("t1_wc", 32'(word_count), 32'd4);
      chk("t1_cs", checksum, exp_cs(32'hAA));
      chk("t1_busy_end", 32'(busy), 32'd0);

      // Frame of 3 with s_valid toggling every cycle
      snap();
      start = 1'b1; frame_len = 10'd3;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bif.s_valid = (i % 2 == 0);
         bif.s_data  = 32'hA0 + 32'(i);
         step();
      end
      bif.s_valid = 1'b0;
      chk("t2_release_ready", 32'(bif.s_ready), 32'd0);
      chk("t2_release_wren", 32'(wr_wren), 32'd0);
      wait_done("t2_done_seen", 30);
      step();
      chk("t2_writes", 32'(wr_cnt - b_wr), 32'd3);
      for (int k = 0; k < 3; k++) begin
         chk("t2_addr", 32'(wr_addr[b_wr + k]), 32'(k));
         chk("t2_data", wr_data[b_wr + k], 32'hA0 + 32'(2 * k));
      end
      chk("t2_wren_low", 32'(low_cnt - b_low), 32'd5);
      chk("t2_wc", 32'(word_count), 32'd3);
      chk("t2_cs", checksum, exp_cs(32'h1E6));

      // Illegal lengths 0 and 513
      snap();
      start = 1'b1; frame_len = 10'd0;
      step();
      start = 1'b0;
      chk("t3_err0", 32'(err), 32'd1);
      chk("t3_busy0", 32'(busy), 32'd0);
      chk("t3_ready0", 32'(bif.s_ready), 32'd0);
      step();
      chk("t3_err_clear", 32'(err), 32'd0);
      start = 1'b1; frame_len = 10'd513;
      step();
      start = 1'b0;
      chk("t3_err513", 32'(err), 32'd1);
      chk("t3_ready513", 32'(bif.s_ready), 32'd0);
      chk("t3_wc_hold", 32'(word_count), 32'd3);
      step();
      chk("t3_err_cnt", 32'(err_cnt - b_err), 32'd2);
      chk("t3_writes", 32'(wr_cnt - b_wr), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);

      // Full depth frame of 512
      snap();
      start = 1'b1; frame_len = 10'd512;
      step();
      start = 1'b0;
      bif.s_valid = 1'b1;
      for (int i = 0; i < 512; i++) begin
         bif.s_data = 32'hC000_0000 + 32'(i);
         step();
      end
      bif.s_valid = 1'b0;
      wait_done("t4_done_seen", 600);
      step();
      chk("t4_writes", 32'(wr_cnt - b_wr), 32'd512);
      chk("t4_first_addr", 32'(wr_addr[b_wr]), 32'd0);
      chk("t4_last_addr", 32'(wr_addr[b_wr + 511]), 32'd511);
      chk("t4_last_data", wr_data[b_wr + 511], 32'hC000_01FF);
      chk("t4_addr0_once", 32'(a0_cnt - b_a0), 32'd1);
      chk("t4_wren_low", 32'(low_cnt - b_low), 32'd514);
      chk("t4_wc", 32'(word_count), 32'd512);
      chk("t4_cs", checksum, exp_cs(32'h0001_FF00));

      // Reset after 2 of 5 words, then a fresh frame of 2
      snap();
      start = 1'b1; frame_len = 10'd5;
      step();
      start = 1'b0;
      bif.s_valid = 1'b1;
      bif.s_data = 32'h55; step();
      bif.s_data = 32'h66; step();
      bif.s_valid = 1'b0;
      #1 resetn = 1'b0;
      #1;
      chk_idle_reset("t5_async");
      step();
      chk("t5_no_done", 32'(done_cnt - b_done), 32'd0);
      resetn = 1'b1;
      snap();
      start = 1'b1; frame_len = 10'd2;
      step();
      start = 1'b0;
      chk("t5_busy", 32'(busy), 32'd1);
      bif.s_valid = 1'b1;
      bif.s_data = 32'h77; step();
      bif.s_data = 32'h88; step();
      bif.s_valid = 1'b0;
      wait_done("t5_done_seen", 30);
      step();
      chk("t5_writes", 32'(wr_cnt - b_wr), 32'd2);
      chk("t5_addr0", 32'(wr_addr[b_wr]), 32'd0);
      chk("t5_addr1", 32'(wr_addr[b_wr + 1]), 32'd1);
      chk("t5_data0", wr_data[b_wr], 32'h77);
      chk("t5_data1", wr_data[b_wr + 1], 32'h88);
      chk("t5_wc", 32'(word_count), 32'd2);
      chk("t5_cs", checksum, exp_cs(32'hFF));

      // start pulses during LOAD and RELEASE are ignored
      snap();
      start = 1'b1; frame_len = 10'd2;
      step();
      start = 1'b1; frame_len = 10'd3;
      bif.s_valid = 1'b1; bif.s_data = 32'h1;
      step();
      start = 1'b0;
      bif.s_data = 32'h2;
      step();
      bif.s_valid = 1'b0;
      start = 1'b1; frame_len = 10'd1;
      step();
      start = 1'b0;
      chk("t6_in_release", 32'(wr_wren), 32'd0);
      wait_done("t6_done_seen", 30);
      step(); step(); step();
      chk("t6_done_cnt", 32'(done_cnt - b_done), 32'd1);
      chk("t6_err_cnt", 32'(err_cnt - b_err), 32'd0);
      chk("t6_writes", 32'(wr_cnt - b_wr), 32'd2);
      chk("t6_wren_low", 32'(low_cnt - b_low), 32'd4);
      chk("t6_wc", 32'(word_count), 32'd2);
      chk("t6_cs", checksum, exp_cs(32'h3));
      chk("t6_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
